// File: rtl/ped_request_pkg.sv
// Shared pedestrian-request definitions: channel FSM states and default timing constants.
package ped_request_pkg;

  localparam int unsigned DefDebounce = 20;
  localparam int unsigned DefWalk     = 20;

  typedef enum logic [2:0] {
    StIdle,
    StDeb,
    StLatched,
    StServing,
    StDone
  } ped_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ped_channel.sv
// One pedestrian crossing channel: button synchronizer, debounce/serve FSM and a shared
// saturating counter used both for debouncing and for timing the walk phase.
module ped_channel
  import ped_request_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DefDebounce,
  parameter int unsigned WALK     = DefWalk
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic red,
  output logic ped,
  output logic walk
);

  localparam int unsigned CntW = $clog2(max_u(DEBOUNCE, WALK) + 1);
  localparam logic [CntW-1:0] DebCnt  = CntW'(DEBOUNCE);
  localparam logic [CntW-1:0] WalkCnt = CntW'(WALK);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

  logic            sync1_q, sync2_q;
  ped_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            ped_q, walk_q;

  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (sync2_q) begin
          state_d = StDeb;
          cnt_d   = CntOne;
        end
      end
      StDeb: begin
        // A low sample always wins, so a press must be seen DEBOUNCE+1 times to latch.
        if (!sync2_q) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == DebCnt) begin
          state_d = StLatched;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StLatched: begin
        if (red) begin
          state_d = StServing;
          cnt_d   = CntOne;
        end
      end
      StServing: begin
        if (cnt_q == WalkCnt) begin
          state_d = StDone;
          cnt_d   = '0;
        end else if (!red) begin
          state_d = StLatched;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StDone: begin
        if (!sync2_q) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= StIdle;
      cnt_q   <= '0;
      ped_q   <= 1'b0;
      walk_q  <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ped_q   <= (state_d == StLatched) || (state_d == StServing);
      walk_q  <= (state_d == StServing);
    end
  end

  assign ped  = ped_q;
  assign walk = walk_q;

endmodule

// File: rtl/ped_request.sv
// Pedestrian request front end: two independent channels feeding the traffic controller.
module ped_request
  import ped_request_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DefDebounce,
  parameter int unsigned WALK     = DefWalk
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_ns,
  input  logic btn_ew,
  input  logic ns_red,
  input  logic ew_red,
  output logic ped_NS,
  output logic ped_EW,
  output logic walk_ns,
  output logic walk_ew
);

  ped_channel #(
    .DEBOUNCE(DEBOUNCE),
    .WALK    (WALK)
  ) u_ns (
    .clk (clk),
    .rst (rst),
    .btn (btn_ns),
    .red (ns_red),
    .ped (ped_NS),
    .walk(walk_ns)
  );

  ped_channel #(
    .DEBOUNCE(DEBOUNCE),
    .WALK    (WALK)
  ) u_ew (
    .clk (clk),
    .rst (rst),
    .btn (btn_ew),
    .red (ew_red),
    .ped (ped_EW),
    .walk(walk_ew)
  );

endmodule
